vga_timing_generator: RTL

- Produces the VGA scan timing (pixel_x, pixel_y, display_enable) that the graphics mixer consumes.
- Registers the mixer's RRRGGGBB pixel result onto the VGA pins, aligned with hsync/vsync.
- Generates frame_start and vblank_start strobes so game and player logic update positions outside the visible area.
- Default timing is 640x480@60 with a 25 MHz pixel rate derived from the system clock.

---
 rtl/vga_timing_generator.sv | 113 +++++++++++
 1 files changed

// File: rtl/vga_timing_generator.sv
// VGA scan timing generator: pixel-rate divider, h/v counters, frame strobes,
// and a one-pixel-latency output stage driving colour and sync pins.
module vga_timing_generator #(
    parameter int unsigned H_VISIBLE   = 640,
    parameter int unsigned H_FRONT     = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned V_VISIBLE   = 480,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BACK      = 33,
    parameter int unsigned CLK_DIV     = 2,
    parameter bit          SYNC_ACTIVE = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pixel_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       display_enable,
    output logic       frame_start,
    output logic       vblank_start,
    input  logic [7:0] pixel_color_in_332,
    output logic [2:0] vga_r,
    output logic [2:0] vga_g,
    output logic [1:0] vga_b,
    output logic       vga_hsync,
    output logic       vga_vsync
);

    localparam int unsigned CNT_W    = 10;
    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
    localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

    logic [DIV_W-1:0] r_div;
    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_v;
    logic             r_hsync;
    logic             r_vsync;
    logic [7:0]       r_rgb;

    logic w_tick;
    logic w_h_last;
    logic w_v_last;
    logic w_de;
    logic w_hs_raw;
    logic w_vs_raw;

    // With CLK_DIV=1 the divider sits at 0 and the tick is permanently high.
    assign w_tick   = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_h_last = (r_h == CNT_W'(H_TOTAL - 1));
    assign w_v_last = (r_v == CNT_W'(V_TOTAL - 1));
    assign w_de     = (r_h < CNT_W'(H_VISIBLE)) && (r_v < CNT_W'(V_VISIBLE));
    assign w_hs_raw = (r_h >= CNT_W'(HS_START)) && (r_h <= CNT_W'(HS_END));
    assign w_vs_raw = (r_v >= CNT_W'(VS_START)) && (r_v <= CNT_W'(VS_END));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // Raster counters: h wraps every line, v advances on the h wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_tick) begin
            if (w_h_last) begin
                r_h <= '0;
                r_v <= w_v_last ? '0 : r_v + CNT_W'(1);
            end else begin
                r_h <= r_h + CNT_W'(1);
            end
        end
    end

    // Pin stage: colour and sync for count N appear during count N+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hsync <= ~SYNC_ACTIVE;
            r_vsync <= ~SYNC_ACTIVE;
            r_rgb   <= 8'h00;
        end else if (w_tick) begin
            r_hsync <= w_hs_raw ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_vsync <= w_vs_raw ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_rgb   <= w_de ? pixel_color_in_332 : 8'h00;
        end
    end

    assign pixel_tick     = w_tick;
    assign pixel_x        = r_h;
    assign pixel_y        = r_v;
    assign display_enable = w_de;
    assign frame_start    = w_tick && (r_h == '0) && (r_v == '0);
    assign vblank_start   = w_tick && (r_h == '0) && (r_v == CNT_W'(V_VISIBLE));

    assign vga_r     = r_rgb[7:5];
    assign vga_g     = r_rgb[4:2];
    assign vga_b     = r_rgb[1:0];
    assign vga_hsync = r_hsync;
    assign vga_vsync = r_vsync;

endmodule
